// File: rtl/bram_arbiter.sv
// Round-robin front end sharing one single-port-per-direction BRAM between N_REQ
// requesters: one write and one read granted per cycle, read data steered back.

module bram_wrapper #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 10,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             w_valid,
   input  logic [AW-1:0]    w_address,
   input  logic [WIDTH-1:0] w_data,
   input  logic             ar_valid,
   input  logic [AW-1:0]    ar_address,
   output logic             r_valid,
   output logic [WIDTH-1:0] r_data
);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             w_in_range;
   logic             ar_in_range;
   logic             r_valid_d, r_valid_q;
   logic [WIDTH-1:0] r_data_d, r_data_q;

   // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latch is inferred.
   always_comb begin
      w_in_range  = ({1'b0, w_address} < DEPTH_L);
      ar_in_range = ({1'b0, ar_address} < DEPTH_L);
      r_valid_d   = ar_valid;
      r_data_d    = r_data_q;
      if (ar_valid && ar_in_range) r_data_d = mem[ar_address];
   end

   // NOTE: the storage array has no reset; clearing it would defeat block-RAM inference.
   always_ff @(posedge clk) begin
      if (w_valid && w_in_range) mem[w_address] <= w_data;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_valid_q <= 1'b0;
      else       r_valid_q <= r_valid_d;
   end

   always_ff @(posedge clk) r_data_q <= r_data_d;

   assign r_valid = r_valid_q;
   assign r_data  = r_data_q;
endmodule

module bram_arbiter #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 10,
   parameter int N_REQ = 2,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_write,
   input  logic [N_REQ*AW-1:0]    req_address,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]       resp_data
);
   localparam int PW = $clog2(N_REQ);

   logic [N_REQ-1:0] w_req, r_req, w_gnt, r_gnt;
   logic             w_found, r_found, w_ok, r_ok;
   int               w_idx, r_idx, w_cand, r_cand;
   logic [PW-1:0]    wptr_d, wptr_q, rptr_d, rptr_q;
   logic [PW-1:0]    rd_owner_d, rd_owner_q;
   logic             fwd_d, fwd_q;
   logic [WIDTH-1:0] fwd_data_d, fwd_data_q;
   logic             w_valid, ar_valid, r_valid;
   logic [AW-1:0]    w_address, ar_address;
   logic [WIDTH-1:0] w_data, r_data;
   logic             bram_reset;

   always_comb begin
      w_req   = req_valid & req_write;
      r_req   = req_valid & ~req_write;
      w_found = 1'b0;
      r_found = 1'b0;
      w_idx   = 0;
      r_idx   = 0;
      w_cand  = 0;
      r_cand  = 0;
      // First asserted index at or after the pointer, wrapping modulo N_REQ
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = (int'(wptr_q) + k) % N_REQ;
         r_cand = (int'(rptr_q) + k) % N_REQ;
         if (!w_found && w_req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
         if (!r_found && r_req[r_cand]) begin
            r_found = 1'b1;
            r_idx   = r_cand;
         end
      end
      w_ok  = w_found & reset_n;
      r_ok  = r_found & reset_n;
      w_gnt = '0;
      r_gnt = '0;
      if (w_ok) w_gnt[w_idx] = 1'b1;
      if (r_ok) r_gnt[r_idx] = 1'b1;

      w_valid    = w_ok;
      w_address  = req_address[w_idx*AW +: AW];
      w_data     = req_data[w_idx*WIDTH +: WIDTH];
      ar_valid   = r_ok;
      ar_address = req_address[r_idx*AW +: AW];

      wptr_d     = w_ok ? PW'((w_idx + 1) % N_REQ) : wptr_q;
      rptr_d     = r_ok ? PW'((r_idx + 1) % N_REQ) : rptr_q;
      rd_owner_d = r_ok ? PW'(r_idx) : rd_owner_q;
      // A read racing a write to the same word must see the new data, not the BRAM's old word
      fwd_d      = w_ok & r_ok & (w_address == ar_address);
      fwd_data_d = w_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         rd_owner_q <= '0;
         fwd_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         rd_owner_q <= rd_owner_d;
         fwd_q      <= fwd_d;
      end
   end

   always_ff @(posedge clk) fwd_data_q <= fwd_data_d;

   assign bram_reset = ~reset_n;

   bram_wrapper #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .AW   (AW)
   ) u_bram (
      .clk       (clk),
      .reset     (bram_reset),
      .w_valid   (w_valid),
      .w_address (w_address),
      .w_data    (w_data),
      .ar_valid  (ar_valid),
      .ar_address(ar_address),
      .r_valid   (r_valid),
      .r_data    (r_data)
   );

   always_comb begin
      req_ready = w_gnt | r_gnt;
      for (int i = 0; i < N_REQ; i++) resp_valid[i] = r_valid && (rd_owner_q == PW'(i));
      resp_data = fwd_q ? fwd_data_q : r_data;
   end
endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Round-robin arbiter that shares one `bram_wrapper` instance between `N_REQ` requesters. Each requester issues single-beat read or write requests over a valid/ready handshake. The arbiter grants at most one write and one read per cycle, using independent round-robin pointers for each. Read data returns one cycle after acceptance, steered to the requester that issued it. The block sits between client engines (DMA, table updaters) and the shared on-chip memory.

## Interface
- `WIDTH`, 10, data width in bits; passed to `bram_wrapper`.
- `DEPTH`, 10, number of words; `AW = $clog2(DEPTH)`.
- `N_REQ`, 2, number of requesters, 2..8.
- `clk`  input  1  single clock; all logic on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset; `bram_wrapper` reset driven by `!reset_n`.
- `req_valid`  input  N_REQ  per-requester request valid.
- `req_write`  input  N_REQ  1 = write, 0 = read; qualified by `req_valid`.
- `req_address`  input  N_REQ*AW  requester i uses bits `[i*AW +: AW]`.
- `req_data`  input  N_REQ*WIDTH  write data; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  output  N_REQ  grant; combinational from `req_valid`, `req_write` and the pointers.
- `resp_valid`  output  N_REQ  one-hot read-data valid for the owning requester.
- `resp_data`  output  WIDTH  read data, shared by all requesters; valid where `resp_valid[i]`.

## Operation
- Acceptance: a request is accepted in any cycle where `req_valid[i] & req_ready[i]` is high.
- Request stability: a requester holds its request stable until accepted. The arbiter does not check this.
- Two classes:
  - Write class: requesters with `req_valid & req_write`.
  - Read class: requesters with `req_valid & !req_write`.
- Each class has its own round-robin arbiter with pointer `wptr` or `rptr` (AW-independent, `$clog2(N_REQ)` bits).
- Search order: starting at the pointer, the first asserted index in ascending order, modulo `N_REQ`, wins. At most one `req_ready` per class is high.
- Pointer update: on a grant in a class, that class's pointer becomes `(granted + 1) mod N_REQ`. With no grant, the pointer holds.
- Write grant: drives `w_valid = 1`, `w_address` and `w_data` from the winner, all combinationally into `bram_wrapper`.
- Read grant: drives `ar_valid = 1` and `ar_address` from the winner. The arbiter registers the winner index (`rd_owner`) and a forward flag.
- Same-cycle forwarding: when a write and a read are granted in the same cycle with equal addresses, the read response returns the write's data, not the old contents. The arbiter registers the write data alongside `rd_owner` and muxes it onto `resp_data`.
- Response: `resp_valid[rd_owner] = r_valid`; all other bits are 0. Responses have no backpressure; requesters must always accept them.
- Address range: addresses `>= DEPTH` are outside the defined range, with no error reporting.
- No state machine beyond the two pointers, the registered owner and the forward registers.

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream):
  - `wptr = rptr = 0`, `rd_owner = 0`, forward flag 0.
  - `resp_valid = 0`.
  - `req_ready = 0` while `reset_n` is low.
- `resp_data` is undefined until the first response.
- Read latency: exactly 1 cycle. A read accepted on edge k gives `resp_valid` high during the cycle after edge k+1's... precisely: accepted in cycle k, response presented in cycle k+1.
- Write visibility: a write accepted in cycle k is visible to a read accepted in cycle k (through forwarding) or in any later cycle.
- Throughput: one write plus one read per cycle sustained, e.g. from two different requesters.
- Same requester: at most one request per cycle by construction, since it has a single request port.
- Reset mid-operation: an in-flight read is dropped and no `resp_valid` is produced. Pointers return to 0.

## Test plan
- Reset then single access:
  - Stimulus: requester 0 writes addr 3 = 0x155 in cycle 0, then reads addr 3.
  - Required response: `req_ready[0]` high in both cycles; `resp_valid = 01` with `resp_data = 0x155` one cycle after the read is accepted.
- Round-robin fairness (N_REQ = 3):
  - Stimulus: all three requesters hold reads continuously from reset.
  - Required response: grants go 0, 1, 2, 0, 1, 2; `resp_valid` follows the same pattern one cycle later.
- Concurrent classes:
  - Stimulus: requester 0 writes addr 5, requester 1 reads addr 7 in the same cycle.
  - Required response: both `req_ready` bits high; requester 1 receives the old contents of addr 7 next cycle.
- Forwarding:
  - Stimulus: addr 2 holds 0x001; requester 0 writes 0x2AA to addr 2 while requester 1 reads addr 2 in the same cycle.
  - Required response: `resp_valid = 10`, `resp_data = 0x2AA`.
- Pointer hold and skip:
  - Stimulus: only requester 1 reads for 3 cycles, then requesters 0 and 1 both read.
  - Required response: requester 1 is granted each cycle; in the contention cycle `rptr = 0`, so requester 0 wins, then requester 1.
- Reset mid-read:
  - Stimulus: accept a read in cycle k; assert `reset_n` low before edge k+1.
  - Required response: `resp_valid` stays 0. After release, the first grant goes to requester 0.
